decision_trail: RTL and testbench
=================================

# decision_trail

Assignment trail for the hardware SAT/BCP path, sitting directly downstream of the decision engine and the BCP implication unit. It records every assigned variable with its value, origin (decision or implication) and decision level. On a backtrack request it unwinds all entries above a target level and streams each popped variable back upstream so the free-variable bitmap can be restored.

## Interface
- VAR_NUM, 8, number of solver variables; also trail depth
- VAR_WIDTH, 3, variable index width, clog2(VAR_NUM)
- LEVEL_WIDTH, 4, decision level / count width, clog2(VAR_NUM+1)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- push_valid  in  1  assignment offered
- push_ready  out  1  trail can accept a push this cycle
- push_var  in  VAR_WIDTH  assigned variable index
- push_value  in  1  assigned polarity
- push_is_decision  in  1  1 = decision (opens a new level), 0 = implication
- backtrack_req  in  1  start unwinding; sampled only in IDLE
- backtrack_level  in  LEVEL_WIDTH  target level L to keep
- free_valid  out  1  popped variable presented
- free_var  out  VAR_WIDTH  popped variable index
- free_ready  in  1  upstream accepts free_var
- backtrack_done  out  1  one-cycle pulse, unwind complete
- curr_level  out  LEVEL_WIDTH  current decision level
- trail_count  out  LEVEL_WIDTH  entries held
- top_var, top_value, top_is_decision  out  VAR_WIDTH/1/1  top entry (undefined-but-stable when empty)
- full, empty  out  1  trail_count == VAR_NUM / == 0
- err  out  1  sticky: push rejected while full, or level overflow

## Operation
- States: IDLE, POP, DONE. Reset → IDLE.
- push_ready = IDLE && !full && !backtrack_req (backtrack has priority over simultaneous push).
- Push on push_valid && push_ready: entry[trail_count] ← {var, value, is_decision, level}; trail_count+1. Decision: curr_level+1 first, entry stores the new level. Implication: entry stores curr_level.
- push_valid while full in IDLE: ignored, err ← 1. Decision push at curr_level == VAR_NUM: cannot occur without full; treated identically.
- IDLE + backtrack_req: if L >= curr_level → DONE directly, no pops. Else → POP.
- POP: free_valid = 1, free_var = top entry var. On free_ready, pop (trail_count−1). Leave to DONE when the next top would have level <= L or trail empties; the check uses the entry level after the pop, so no extra bubble.
- free_ready low holds POP, free_var stable.
- DONE: backtrack_done = 1, curr_level ← min(L, curr_level); → IDLE.
- No duplicate-variable check; upstream guarantees each variable is pushed at most once between backtracks.

## Timing
- Reset values: push_ready 1 after release, free_valid 0, free_var 0, backtrack_done 0, curr_level 0, trail_count 0, top_* 0, full 0, empty 1, err 0.
- Push visible in trail_count/top_* one cycle after the accepting edge. Back-to-back pushes every cycle are supported.
- Backtrack latency with free_ready held high: 1 (IDLE→POP) + N pops + 1 DONE cycle. N=0 case: 2 cycles to done pulse.
- free_valid, backtrack_done and push_ready are decoded from registered state and count, with no combinational path from free_ready.
- Reset mid-POP: trail cleared immediately, no backtrack_done.

## Structure
- Shared package sat_pkg holds VAR_NUM, VAR_WIDTH, LEVEL_WIDTH, the trail entry record, and the state encoding, all shared with the decision engine and BCP.
- Sub-module trail_mem is a VAR_NUM-entry register file with a write port at trail_count, a read port at trail_count−1, and reset-clear. The FSM, counters and level logic stay in decision_trail.

## Test plan
- Reset then 3 pushes (v2 dec val1, v5 imp val0, v1 dec val1) → trail_count 3, curr_level 2, top_var 1, top_is_decision 1.
- From that state, backtrack L=1 with free_ready=1 → free_var 1 for one cycle, backtrack_done the next cycle, curr_level 1, trail_count 2, top_var 5.
- Backtrack L=0 with free_ready toggling 1,0,1 → free_var sequence 5, 5 (held), 2; empty=1, curr_level 0.
- 8 pushes fill the trail, then a 9th push → push_ready 0, full 1, err 1, trail_count stays 8.
- push_valid and backtrack_req in the same IDLE cycle → push not accepted, backtrack proceeds. Backtrack L=3 at curr_level 2 → done after 2 cycles with no free_valid.
- Assert reset during POP → all outputs return to reset values, no backtrack_done pulse.

Source files
------------

// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared SAT/BCP sizes, trail entry record and trail FSM encoding
package sat_pkg;

    localparam int VAR_NUM     = 8;
    localparam int VAR_WIDTH   = 3;
    localparam int LEVEL_WIDTH = 4;

    typedef struct packed {
        logic [VAR_WIDTH-1:0]   var_idx;
        logic                   value;
        logic                   is_decision;
        logic [LEVEL_WIDTH-1:0] level;
    } trail_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_DONE = 2'd2
    } trail_state_t;

endpackage

// File: rtl/trail_mem.sv
// rtl/trail_mem.sv - VAR_NUM-entry trail register file, one write port, one read port, reset-clear
module trail_mem
    import sat_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [VAR_WIDTH-1:0] wr_addr,
    input  trail_entry_t         wr_data,
    input  logic [VAR_WIDTH-1:0] rd_addr,
    output trail_entry_t         rd_data
);

    trail_entry_t mem_q [VAR_NUM];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VAR_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/decision_trail.sv
// rtl/decision_trail.sv - SAT assignment trail: records assignments, unwinds to a target level on backtrack
module decision_trail
    import sat_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [VAR_WIDTH-1:0]   push_var,
    input  logic                   push_value,
    input  logic                   push_is_decision,
    input  logic                   backtrack_req,
    input  logic [LEVEL_WIDTH-1:0] backtrack_level,
    output logic                   free_valid,
    output logic [VAR_WIDTH-1:0]   free_var,
    input  logic                   free_ready,
    output logic                   backtrack_done,
    output logic [LEVEL_WIDTH-1:0] curr_level,
    output logic [LEVEL_WIDTH-1:0] trail_count,
    output logic [VAR_WIDTH-1:0]   top_var,
    output logic                   top_value,
    output logic                   top_is_decision,
    output logic                   full,
    output logic                   empty,
    output logic                   err
);

    localparam logic [LEVEL_WIDTH-1:0] LVL_ONE  = LEVEL_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(VAR_NUM);

    trail_state_t           state_q, state_d;
    logic [LEVEL_WIDTH-1:0] count_q, count_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [LEVEL_WIDTH-1:0] target_q, target_d;
    logic                   err_q, err_d;

    logic                   mem_we;
    trail_entry_t           wr_entry;
    trail_entry_t           top_entry;
    logic [LEVEL_WIDTH-1:0] count_m1;
    logic                   push_blocked;
    logic                   last_pop;

    assign count_m1     = count_q - LVL_ONE;
    assign full         = (count_q == LVL_FULL);
    assign empty        = (count_q == '0);
    assign push_blocked = full || (push_is_decision && (level_q >= LVL_FULL));

    // Levels only grow by one at a decision, so the entry below the top has
    // level <= target exactly when the top is the decision opening target+1.
    assign last_pop = (count_q == LVL_ONE) ||
                      (top_entry.is_decision && ((top_entry.level - LVL_ONE) <= target_q));

    trail_mem u_trail_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (mem_we),
        .wr_addr (count_q[VAR_WIDTH-1:0]),
        .wr_data (wr_entry),
        .rd_addr (count_m1[VAR_WIDTH-1:0]),
        .rd_data (top_entry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            level_q  <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            level_q  <= level_d;
            target_q <= target_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        count_d              = count_q;
        level_d              = level_q;
        target_d             = target_q;
        err_d                = err_q;
        mem_we               = 1'b0;
        wr_entry.var_idx     = push_var;
        wr_entry.value       = push_value;
        wr_entry.is_decision = push_is_decision;
        wr_entry.level       = push_is_decision ? (level_q + LVL_ONE) : level_q;
        push_ready           = 1'b0;
        free_valid           = 1'b0;
        backtrack_done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                push_ready = !full && !backtrack_req;
                if (backtrack_req) begin
                    target_d = backtrack_level;
                    state_d  = (backtrack_level >= level_q) ? ST_DONE : ST_POP;
                end else if (push_valid) begin
                    if (push_blocked) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + LVL_ONE;
                        level_d = wr_entry.level;
                    end
                end
            end
            ST_POP: begin
                free_valid = 1'b1;
                if (free_ready) begin
                    count_d = count_m1;
                    if (last_pop) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                backtrack_done = 1'b1;
                level_d        = (target_q < level_q) ? target_q : level_q;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign free_var        = free_valid ? top_entry.var_idx : '0;
    assign curr_level      = level_q;
    assign trail_count     = count_q;
    assign top_var         = top_entry.var_idx;
    assign top_value       = top_entry.value;
    assign top_is_decision = top_entry.is_decision;
    assign err             = err_q;

endmodule

// File: tb/tb_decision_trail.sv
// tb/tb_decision_trail.sv - directed self-checking bench for decision_trail
module tb_decision_trail;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic [2:0] push_var = '0;
    logic       push_value = 1'b0;
    logic       push_is_decision = 1'b0;
    logic       backtrack_req = 1'b0;
    logic [3:0] backtrack_level = '0;
    logic       free_valid;
    logic [2:0] free_var;
    logic       free_ready = 1'b0;
    logic       backtrack_done;
    logic [3:0] curr_level;
    logic [3:0] trail_count;
    logic [2:0] top_var;
    logic       top_value;
    logic       top_is_decision;
    logic       full;
    logic       empty;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decision_trail dut (
        .clock           (clock),
        .reset           (reset),
        .push_valid      (push_valid),
        .push_ready      (push_ready),
        .push_var        (push_var),
        .push_value      (push_value),
        .push_is_decision(push_is_decision),
        .backtrack_req   (backtrack_req),
        .backtrack_level (backtrack_level),
        .free_valid      (free_valid),
        .free_var        (free_var),
        .free_ready      (free_ready),
        .backtrack_done  (backtrack_done),
        .curr_level      (curr_level),
        .trail_count     (trail_count),
        .top_var         (top_var),
        .top_value       (top_value),
        .top_is_decision (top_is_decision),
        .full            (full),
        .empty           (empty),
        .err             (err)
    );

    task automatic apply_reset();
        reset = 1'b1;
        push_valid = 1'b0;
        backtrack_req = 1'b0;
        free_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic push(input logic [2:0] v, input logic val, input logic dec);
        push_valid = 1'b1;
        push_var = v;
        push_value = val;
        push_is_decision = dec;
        @(negedge clock);
        push_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
        checks++; if (free_valid !== 1'b0) begin errors++; $display("FAIL reset_free_valid: got %b expected 0", free_valid); end
        checks++; if (free_var !== 3'd0) begin errors++; $display("FAIL reset_free_var: got %0d expected 0", free_var); end
        checks++; if (backtrack_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", backtrack_done); end
        checks++; if (curr_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", curr_level); end
        checks++; if (trail_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", trail_count); end
        checks++; if ({top_var, top_value, top_is_decision} !== 5'd0) begin errors++; $display("FAIL reset_top: got %0d/%b/%b expected 0/0/0", top_var, top_value, top_is_decision); end
        checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_full_empty: got full=%b empty=%b expected 0/1", full, empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_push_three();
        push(3'd2, 1'b1, 1'b1);
        push(3'd5, 1'b0, 1'b0);
        checks++; if (top_var !== 3'd5 || top_is_decision !== 1'b0) begin errors++; $display("FAIL push2_top: got var %0d dec %b expected 5/0", top_var, top_is_decision); end
        push(3'd1, 1'b1, 1'b1);
        checks++; if (trail_count !== 4'd3) begin errors++; $display("FAIL push3_count: got %0d expected 3", trail_count); end
        checks++; if (curr_level !== 4'd2) begin errors++; $display("FAIL push3_level: got %0d expected 2", curr_level); end
        checks++; if (top_var !== 3'd1 || top_is_decision !== 1'b1 || top_value !== 1'b1) begin errors++; $display("FAIL push3_top: got %0d/%b/%b expected 1/1/1", top_var, top_value, top_is_decision); end
    endtask

    task automatic test_backtrack_one();
        backtrack_level = 4'd1;
        backtrack_req = 1'b1;
        free_ready = 1'b1;
        @(negedge clock);
        backtrack_req = 1'b0;
        checks++; if (free_valid !== 1'b1 || free_var !== 3'd1) begin errors++; $display("FAIL bt1_pop: got valid %b var %0d expected 1/1", free_valid, free_var); end
        checks++; if (backtrack_done !== 1'b0) begin errors++; $display("FAIL bt1_early_done: got %b expected 0", backtrack_done); end
        @(negedge clock);
        checks++; if (free_valid !== 1'b0 || backtrack_done !== 1'b1) begin errors++; $display("FAIL bt1_done: got valid %b done %b expected 0/1", free_valid, backtrack_done); end
        @(negedge clock);
        checks++; if (backtrack_done !== 1'b0) begin errors++; $display("FAIL bt1_done_pulse: got %b expected 0", backtrack_done); end
        checks++; if (curr_level !== 4'd1 || trail_count !== 4'd2) begin errors++; $display("FAIL bt1_state: got level %0d count %0d expected 1/2", curr_level, trail_count); end
        checks++; if (top_var !== 3'd5) begin errors++; $display("FAIL bt1_top: got %0d expected 5", top_var); end
    endtask

    task automatic test_backtrack_stall();
        backtrack_level = 4'd0;
        backtrack_req = 1'b1;
        free_ready = 1'b1;
        @(negedge clock);
        backtrack_req = 1'b0;
        free_ready = 1'b0;
        checks++; if (free_valid !== 1'b1 || free_var !== 3'd5) begin errors++; $display("FAIL stall_first: got valid %b var %0d expected 1/5", free_valid, free_var); end
        @(negedge clock);
        free_ready = 1'b1;
        checks++; if (free_valid !== 1'b1 || free_var !== 3'd5 || trail_count !== 4'd2) begin errors++; $display("FAIL stall_hold: got valid %b var %0d count %0d expected 1/5/2", free_valid, free_var, trail_count); end
        @(negedge clock);
        checks++; if (free_valid !== 1'b1 || free_var !== 3'd2) begin errors++; $display("FAIL stall_second: got valid %b var %0d expected 1/2", free_valid, free_var); end
        @(negedge clock);
        checks++; if (backtrack_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", backtrack_done); end
        @(negedge clock);
        free_ready = 1'b0;
        checks++; if (empty !== 1'b1 || curr_level !== 4'd0 || trail_count !== 4'd0) begin errors++; $display("FAIL stall_final: got empty %b level %0d count %0d expected 1/0/0", empty, curr_level, trail_count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push_valid = 1'b1;
            push_var = 3'(i);
            push_value = i[0];
            push_is_decision = (i == 0) || (i == 4);
            @(negedge clock);
        end
        push_valid = 1'b0;
        checks++; if (full !== 1'b1 || trail_count !== 4'd8 || push_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got full %b count %0d ready %b expected 1/8/0", full, trail_count, push_ready); end
        checks++; if (curr_level !== 4'd2 || err !== 1'b0) begin errors++; $display("FAIL fill_level: got level %0d err %b expected 2/0", curr_level, err); end
        push(3'd3, 1'b1, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", err); end
        checks++; if (trail_count !== 4'd8 || top_var !== 3'd7) begin errors++; $display("FAIL overflow_count: got count %0d top %0d expected 8/7", trail_count, top_var); end
    endtask

    task automatic test_push_vs_backtrack();
        push(3'd0, 1'b1, 1'b1);
        push(3'd1, 1'b0, 1'b1);
        push_valid = 1'b1;
        push_var = 3'd6;
        push_is_decision = 1'b0;
        backtrack_level = 4'd3;
        backtrack_req = 1'b1;
        #1;
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got %b expected 0", push_ready); end
        @(negedge clock);
        push_valid = 1'b0;
        backtrack_req = 1'b0;
        checks++; if (backtrack_done !== 1'b1 || free_valid !== 1'b0) begin errors++; $display("FAIL prio_done: got done %b valid %b expected 1/0", backtrack_done, free_valid); end
        checks++; if (trail_count !== 4'd2) begin errors++; $display("FAIL prio_count: got %0d expected 2", trail_count); end
        @(negedge clock);
        checks++; if (curr_level !== 4'd2 || backtrack_done !== 1'b0 || top_var !== 3'd1) begin errors++; $display("FAIL prio_after: got level %0d done %b top %0d expected 2/0/1", curr_level, backtrack_done, top_var); end
    endtask

    task automatic test_reset_mid_pop();
        int done_seen;
        done_seen = 0;
        backtrack_level = 4'd0;
        backtrack_req = 1'b1;
        free_ready = 1'b0;
        @(negedge clock);
        backtrack_req = 1'b0;
        checks++; if (free_valid !== 1'b1 || free_var !== 3'd1) begin errors++; $display("FAIL midpop_enter: got valid %b var %0d expected 1/1", free_valid, free_var); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (free_valid !== 1'b0 || trail_count !== 4'd0 || curr_level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL midpop_reset: got valid %b count %0d level %0d empty %b expected 0/0/0/1", free_valid, trail_count, curr_level, empty); end
        @(negedge clock);
        reset = 1'b0;
        free_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (backtrack_done !== 1'b0) done_seen++;
            @(negedge clock);
        end
        free_ready = 1'b0;
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL midpop_no_done: got %0d pulses expected 0", done_seen); end
        checks++; if (push_ready !== 1'b1 || top_var !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL midpop_idle: got ready %b top %0d err %b expected 1/0/0", push_ready, top_var, err); end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_push_three();
        test_backtrack_one();
        test_backtrack_stall();
        test_fill();
        apply_reset();
        test_push_vs_backtrack();
        test_reset_mid_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
